// File: rtl/serial_transmitter.sv
// Serial frame transmitter: one-cycle frame sync, then DATA_WIDTH bits MSB first.
// Define SSP_TX_CONTINUOUS_EN to chain frames back-to-back without an idle cycle.
module serial_transmitter #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  sspclkin,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] ssptxdata,
   input  logic                  tx_valid,
   output logic                  tx_ack,
   output logic                  sspfssout,
   output logic                  ssptxd,
   output logic                  sspoe_b,
   output logic                  tx_busy
);

   // state  | meaning
   // IDLE   | waiting for tx_valid; pad disabled
   // FRAME  | word captured, frame sync cycle
   // SHIFT  | driving data bits, MSB first
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FRAME = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
`ifdef SSP_TX_CONTINUOUS_EN
   localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(DATA_WIDTH - 2);
`endif

   logic [1:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] sh_q, sh_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  tx_ack_q, tx_ack_d;
   logic                  fss_q, fss_d;
   logic                  txd_q, txd_d;
   logic                  oe_b_q, oe_b_d;
   logic                  busy_q, busy_d;

   always_comb begin
      state_d  = state_q;
      sh_d     = sh_q;
      cnt_d    = cnt_q;
      tx_ack_d = 1'b0;
      fss_d    = 1'b0;
      txd_d    = txd_q;
      oe_b_d   = oe_b_q;
      case (state_q)
         ST_IDLE: begin
            txd_d  = 1'b0;
            oe_b_d = 1'b1;
            if (tx_valid) begin
               sh_d     = ssptxdata;
               tx_ack_d = 1'b1;
               fss_d    = 1'b1;
               state_d  = ST_FRAME;
            end
         end
         ST_FRAME: begin
            txd_d   = sh_q[DATA_WIDTH-1];
            sh_d    = {sh_q[DATA_WIDTH-2:0], 1'b0};
            oe_b_d  = 1'b0;
            cnt_d   = '0;
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (cnt_q == CNT_LAST) begin
               txd_d   = 1'b0;
               oe_b_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               txd_d  = sh_q[DATA_WIDTH-1];
               sh_d   = {sh_q[DATA_WIDTH-2:0], 1'b0};
               oe_b_d = 1'b0;
               cnt_d  = cnt_q + CNT_W'(1);
`ifdef SSP_TX_CONTINUOUS_EN
               // bit[0] goes out on this edge; chain the next word straight in
               if (cnt_q == CNT_PEN && tx_valid) begin
                  sh_d     = ssptxdata;
                  tx_ack_d = 1'b1;
                  fss_d    = 1'b1;
                  state_d  = ST_FRAME;
               end
`endif
            end
         end
         default: begin
            txd_d   = 1'b0;
            oe_b_d  = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge sspclkin or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         sh_q     <= '0;
         cnt_q    <= '0;
         tx_ack_q <= 1'b0;
         fss_q    <= 1'b0;
         txd_q    <= 1'b0;
         oe_b_q   <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sh_q     <= sh_d;
         cnt_q    <= cnt_d;
         tx_ack_q <= tx_ack_d;
         fss_q    <= fss_d;
         txd_q    <= txd_d;
         oe_b_q   <= oe_b_d;
         busy_q   <= busy_d;
      end
   end

   assign tx_ack    = tx_ack_q;
   assign sspfssout = fss_q;
   assign ssptxd    = txd_q;
   assign sspoe_b   = oe_b_q;
   assign tx_busy   = busy_q;

endmodule
